// File: rtl/zion_dat_write_pkg.sv
// Shared types and byte-lane helpers for the narrow-to-wide write merge path.
// Masks are built at the widest supported line and truncated by the user.
package zion_dat_write_pkg;

  localparam int MAX_LINE_BYTES = 128;

  typedef enum logic [1:0] {
    IDLE,
    MERGE,
    FLUSH
  } state_t;

  function automatic logic [MAX_LINE_BYTES-1:0] byte_mask(input int widthBytes, input int offset);
    logic [MAX_LINE_BYTES-1:0] m;
    m = '0;
    for (int b = 0; b < MAX_LINE_BYTES; b++) begin
      m[b] = (b >= offset) && (b < offset + widthBytes);
    end
    return m;
  endfunction

  function automatic logic is_aligned(input int widthBytes, input int offset);
    return (widthBytes > 0) && ((offset % widthBytes) == 0);
  endfunction

endpackage

// File: rtl/zion_dat_write_lane_merge.sv
// Combinational byte-lane merge: drops a right-aligned narrow write into the line at offset.
// No latency, no flow control; the caller decides whether the result is committed.
module zion_dat_write_lane_merge
  import zion_dat_write_pkg::*;
#(
  parameter int WIDTH_DATA_IN = 32,
  parameter int WIDTH_LINE    = 128
) (
  input  logic [WIDTH_LINE-1:0]         line,
  input  logic [WIDTH_LINE/8-1:0]       mask,
  input  logic [WIDTH_DATA_IN-1:0]      iDat,
  input  logic [15:0]                   typeBytes,
  input  logic [$clog2(WIDTH_LINE/8)-1:0] offset,
  output logic [WIDTH_LINE-1:0]         newLine,
  output logic [WIDTH_LINE/8-1:0]       newMask
);

  localparam int LINE_BYTES = WIDTH_LINE / 8;
  localparam int IN_BYTES   = WIDTH_DATA_IN / 8;

  always_comb begin
    newLine = line;
    newMask = mask | LINE_BYTES'(byte_mask(int'(typeBytes), int'(offset)));
    for (int b = 0; b < LINE_BYTES; b++) begin
      for (int k = 0; k < IN_BYTES; k++) begin
        if ((k < int'(typeBytes)) && (b == int'(offset) + k)) begin
          newLine[b*8 +: 8] = iDat[k*8 +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/zion_dat_write_merge.sv
// Merges narrow aligned writes into one wide masked line; flush is registered (oVld the cycle after the trigger).
// Different-tag writes stall via oRdy while the held line drains; oRdy never depends on iRdy.
module zion_dat_write_merge
  import zion_dat_write_pkg::*;
#(
  parameter int WIDTH_TYPE_NUM                    = 3,
  parameter int MULTI_DATA_WIDTH [WIDTH_TYPE_NUM] = '{8, 16, 32},
  parameter int WIDTH_DATA_IN                     = 32,
  parameter int WIDTH_LINE                        = 128,
  parameter int WIDTH_ADDR                        = 32,
  parameter int TIMEOUT                           = 15
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      iVld,
  output logic                      oRdy,
  input  logic [WIDTH_TYPE_NUM-1:0] iEn,
  input  logic [WIDTH_ADDR-1:0]     iAddr,
  input  logic [WIDTH_DATA_IN-1:0]  iDat,
  input  logic                      iFlush,
  output logic                      oVld,
  input  logic                      iRdy,
  output logic [WIDTH_ADDR-1:0]     oAddr,
  output logic [WIDTH_LINE-1:0]     oDat,
  output logic [WIDTH_LINE/8-1:0]   oMask,
  output logic                      oErr
);

  localparam int LINE_BYTES = WIDTH_LINE / 8;
  localparam int OFS_W      = $clog2(LINE_BYTES);
  localparam int TAG_W      = WIDTH_ADDR - OFS_W;
  localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

  state_t                  state, stateNxt;
  logic [TAG_W-1:0]        tagQ;
  logic [WIDTH_LINE-1:0]   lineQ, lineNxt, mergedLine;
  logic [LINE_BYTES-1:0]   maskQ, maskNxt, mergedMask;
  logic [CNT_W-1:0]        cntQ, cntNxt;
  logic                    errQ;
  logic [TAG_W-1:0]        inTag;
  logic [OFS_W-1:0]        inOfs;
  logic [15:0]             typeBytes;
  logic                    legal, tagHit, timeoutHit, accept, loadTag;

  assign inTag = iAddr[WIDTH_ADDR-1:OFS_W];
  assign inOfs = iAddr[OFS_W-1:0];

  always_comb begin
    typeBytes = '0;
    for (int t = 0; t < WIDTH_TYPE_NUM; t++) begin
      if (iEn[t]) typeBytes = typeBytes | 16'(MULTI_DATA_WIDTH[t] / 8);
    end
  end

  assign legal      = $onehot(iEn) && is_aligned(int'(typeBytes), int'(inOfs));
  assign tagHit     = (inTag == tagQ);
  assign timeoutHit = (TIMEOUT != 0) && (cntQ == CNT_MAX);
  assign accept     = iVld & oRdy;

  zion_dat_write_lane_merge #(
    .WIDTH_DATA_IN(WIDTH_DATA_IN),
    .WIDTH_LINE   (WIDTH_LINE)
  ) uLaneMerge (
    .line     (lineQ),
    .mask     (maskQ),
    .iDat     (iDat),
    .typeBytes(typeBytes),
    .offset   (inOfs),
    .newLine  (mergedLine),
    .newMask  (mergedMask)
  );

  always_comb begin
    stateNxt = state;
    lineNxt  = lineQ;
    maskNxt  = maskQ;
    cntNxt   = cntQ;
    loadTag  = 1'b0;
    oRdy     = 1'b0;
    case (state)
      IDLE: begin
        oRdy = 1'b1;
        if (iVld && legal) begin
          loadTag  = 1'b1;
          lineNxt  = mergedLine;
          maskNxt  = mergedMask;
          cntNxt   = '0;
          stateNxt = (&mergedMask) ? FLUSH : MERGE;
        end
      end
      MERGE: begin
        oRdy = ~(iVld & ~tagHit);
        if (iVld && tagHit) begin
          // an illegal same-tag write is still an accept: counter holds, buffer untouched
          if (legal) begin
            lineNxt = mergedLine;
            maskNxt = mergedMask;
            cntNxt  = '0;
          end
        end else begin
          cntNxt = (cntQ == CNT_MAX) ? cntQ : cntQ + 1'b1;
        end
        if ((&maskNxt) || (iVld && !tagHit) || iFlush || timeoutHit) begin
          stateNxt = FLUSH;
          cntNxt   = '0;
        end
      end
      FLUSH: begin
        if (iRdy) begin
          lineNxt  = '0;
          maskNxt  = '0;
          stateNxt = IDLE;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      tagQ  <= '0;
      lineQ <= '0;
      maskQ <= '0;
      cntQ  <= '0;
      errQ  <= 1'b0;
    end else begin
      state <= stateNxt;
      lineQ <= lineNxt;
      maskQ <= maskNxt;
      cntQ  <= cntNxt;
      errQ  <= accept & ~legal;
      if (loadTag) tagQ <= inTag;
    end
  end

  assign oVld  = (state == FLUSH);
  assign oAddr = {tagQ, {OFS_W{1'b0}}};
  assign oDat  = lineQ;
  assign oMask = maskQ;
  assign oErr  = errQ;

endmodule

// File: tb/tb_zion_dat_write_merge.sv
// Directed bench for zion_dat_write_merge: TIMEOUT=4 main instance plus a TIMEOUT=0 instance.
module tb_zion_dat_write_merge;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         iVld, iFlush, iRdy;
  logic [2:0]   iEn;
  logic [31:0]  iAddr, iDat;
  logic         oRdy, oVld, oErr;
  logic [31:0]  oAddr;
  logic [127:0] oDat;
  logic [15:0]  oMask;

  logic         zVld, zFlush, zRdyIn;
  logic [2:0]   zEn;
  logic [31:0]  zAddr, zDat;
  logic         zoRdy, zoVld, zoErr;
  logic [31:0]  zoAddr;
  logic [127:0] zoDat;
  logic [15:0]  zoMask;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  zion_dat_write_merge #(.TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .iVld(iVld), .oRdy(oRdy), .iEn(iEn), .iAddr(iAddr),
    .iDat(iDat), .iFlush(iFlush), .oVld(oVld), .iRdy(iRdy), .oAddr(oAddr),
    .oDat(oDat), .oMask(oMask), .oErr(oErr)
  );

  zion_dat_write_merge #(.TIMEOUT(0)) dutNoTo (
    .clk(clk), .rst_n(rst_n), .iVld(zVld), .oRdy(zoRdy), .iEn(zEn), .iAddr(zAddr),
    .iDat(zDat), .iFlush(zFlush), .oVld(zoVld), .iRdy(zRdyIn), .oAddr(zoAddr),
    .oDat(zoDat), .oMask(zoMask), .oErr(zoErr)
  );

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // presented at a negedge, accepted at the following posedge; returns at the next negedge
  task automatic wr(input logic [2:0] en, input logic [31:0] a, input logic [31:0] d);
    iVld  = 1'b1;
    iEn   = en;
    iAddr = a;
    iDat  = d;
    step();
    iVld  = 1'b0;
  endtask

  task automatic drain();
    iRdy = 1'b1;
    step();
    iRdy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;
    rst_n = 1'b0;
    iVld = 0; iEn = '0; iAddr = '0; iDat = '0; iFlush = 0; iRdy = 0;
    zVld = 0; zEn = '0; zAddr = '0; zDat = '0; zFlush = 0; zRdyIn = 0;
    @(negedge clk);
    check("rst_oVld", oVld, 0);
    check("rst_oErr", oErr, 0);
    check("rst_oMask", oMask, 0);
    check("rst_oDat", oDat, 0);
    check("rst_oAddr", oAddr, 0);
    check("rst_oRdy", oRdy, 1);
    rst_n = 1'b1;
    step();

    // 1: four word writes fill the line
    wr(3'b100, 32'h100, 32'h11111111);
    wr(3'b100, 32'h104, 32'h22222222);
    wr(3'b100, 32'h108, 32'h33333333);
    wr(3'b100, 32'h10C, 32'h44444444);
    check("t1_oVld", oVld, 1);
    check("t1_oRdy", oRdy, 0);
    check("t1_oAddr", oAddr, 32'h100);
    check("t1_oMask", oMask, 16'hFFFF);
    check("t1_oDat", oDat, 128'h44444444_33333333_22222222_11111111);
    drain();
    check("t1_idle_oVld", oVld, 0);
    check("t1_idle_oMask", oMask, 0);

    // 2: single byte then explicit flush
    wr(3'b001, 32'h203, 32'h000000AB);
    check("t2_noVld", oVld, 0);
    iFlush = 1'b1;
    step();
    iFlush = 1'b0;
    check("t2_oVld", oVld, 1);
    check("t2_oAddr", oAddr, 32'h200);
    check("t2_oMask", oMask, 16'h0008);
    check("t2_oDat", oDat, 128'hAB000000);
    drain();

    // 3: different tag stalls until the held line drains
    wr(3'b010, 32'h300, 32'h0000BEEF);
    iVld = 1'b1; iEn = 3'b100; iAddr = 32'h310; iDat = 32'h12345678;
    #1 check("t3_stall_oRdy", oRdy, 0);
    step();
    check("t3_flush_oVld", oVld, 1);
    check("t3_flush_oRdy", oRdy, 0);
    check("t3_flush_oAddr", oAddr, 32'h300);
    check("t3_flush_oMask", oMask, 16'h0003);
    check("t3_flush_oDat", oDat, 128'hBEEF);
    drain();
    check("t3_idle_oVld", oVld, 0);
    check("t3_idle_oRdy", oRdy, 1);
    step();
    iVld = 1'b0;
    iFlush = 1'b1;
    step();
    iFlush = 1'b0;
    check("t3_second_oVld", oVld, 1);
    check("t3_second_oAddr", oAddr, 32'h310);
    check("t3_second_oMask", oMask, 16'h000F);
    check("t3_second_oDat", oDat, 128'h12345678);
    drain();

    // 4: misaligned half and non-one-hot type are dropped with a one-cycle oErr
    wr(3'b010, 32'h101, 32'h0000BEEF);
    check("t4_err1", oErr, 1);
    check("t4_err1_oVld", oVld, 0);
    check("t4_err1_oMask", oMask, 0);
    step();
    check("t4_err1_end", oErr, 0);
    wr(3'b011, 32'h104, 32'h00001234);
    check("t4_err2", oErr, 1);
    check("t4_err2_oMask", oMask, 0);
    step();
    check("t4_err2_end", oErr, 0);
    check("t4_err2_oVld", oVld, 0);
    wr(3'b001, 32'h105, 32'h11);
    wr(3'b001, 32'h105, 32'h22);
    check("t4_legal_oErr", oErr, 0);
    check("t4_merge_oMask", oMask, 16'h0020);
    iFlush = 1'b1;
    step();
    iFlush = 1'b0;
    check("t4_flush_oVld", oVld, 1);
    check("t4_flush_oAddr", oAddr, 32'h100);
    check("t4_flush_oDat", oDat, 128'h22_0000000000);
    drain();

    // 5: timeout flush; oVld rises with the 5th posedge after the accept edge (cycle N+6)
    wr(3'b001, 32'h400, 32'h5A);
    n = 0;
    while (!oVld && n < 20) begin
      step();
      n++;
    end
    check("t5_latency", n, 5);
    check("t5_oAddr", oAddr, 32'h400);
    check("t5_oMask", oMask, 16'h0001);
    check("t5_oDat", oDat, 128'h5A);
    drain();

    // 5b: TIMEOUT=0 never auto-flushes
    zVld = 1'b1; zEn = 3'b001; zAddr = 32'h400; zDat = 32'h5A;
    step();
    zVld = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      step();
      if (zoVld) seen = 1'b1;
    end
    check("t5_to0_noflush", seen, 0);
    check("t5_to0_oMask", zoMask, 16'h0001);
    zFlush = 1'b1;
    step();
    zFlush = 1'b0;
    check("t5_to0_manual_flush", zoVld, 1);

    // 6: held FLUSH stays stable, then reset discards it asynchronously
    wr(3'b100, 32'h500, 32'hDEADBEEF);
    iFlush = 1'b1;
    step();
    iFlush = 1'b0;
    iVld = 1'b1; iEn = 3'b100; iAddr = 32'h600; iDat = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("t6_hold_oVld", oVld, 1);
      check("t6_hold_oRdy", oRdy, 0);
      check("t6_hold_oAddr", oAddr, 32'h500);
      check("t6_hold_oMask", oMask, 16'h000F);
      check("t6_hold_oDat", oDat, 128'hDEADBEEF);
      step();
    end
    iVld = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_oVld", oVld, 0);
    check("t6_rst_oMask", oMask, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("t6_post_oVld", oVld, 0);
    check("t6_post_oMask", oMask, 0);
    check("t6_post_oRdy", oRdy, 1);
    check("t6_post_oErr", oErr, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
